// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg -- shared definitions for the interpolation sequencing controller.
//
// Contents:
//   - block geometry defaults (input rows per block, output words per block)
//   - datapath word widths seen by the row shift register and output filler
//   - width of the word/row index carried on out_sel
//   - controller state encoding (state_t)
//   - in_block(): true while a block is actively moving data
//
// No ports; imported by interp_beat_counter and interp_seq_ctrl.
// -----------------------------------------------------------------------------
package interp_pkg;

    // One block = IN_ROWS_DEF rows of ROW_W bits in, OUT_WORDS_DEF words of
    // WORD_W bits out (8x8 pixels x 5 planes = 40 words).
    localparam int IN_ROWS_DEF   = 15;
    localparam int OUT_WORDS_DEF = 40;
    localparam int ROW_W         = 120;
    localparam int WORD_W        = 64;

    // Width of the index on out_sel; also used for both beat counters.
    localparam int SEL_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_FILTER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // States in which a block is in flight and may be abandoned.
    function automatic logic in_block(input state_t s);
        return (s == ST_FILL) || (s == ST_FILTER);
    endfunction

endpackage : interp_pkg

// File: rtl/interp_beat_counter.sv
// -----------------------------------------------------------------------------
// interp_beat_counter -- saturating up-counter with a terminal-count flag.
//
// Counts accepted beats (input rows or output words). The count stops at
// TERMINAL and never wraps; terminal is high while count == TERMINAL, so the
// owner can act on the same edge that accepts the final beat.
//
// Parameters:
//   WIDTH     counter width in bits
//   TERMINAL  last value the counter will reach (must fit in WIDTH bits)
//
// Ports:
//   clock     in   rising-edge clock
//   reset_L   in   asynchronous active-low reset, count -> 0
//   clear     in   synchronous clear, has priority over enable
//   enable    in   count one beat this cycle
//   count     out  current beat index
//   terminal  out  count has reached TERMINAL
// -----------------------------------------------------------------------------
module interp_beat_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 14
) (
    input  logic             clock,
    input  logic             reset_L,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    assign terminal = (count == WIDTH'(TERMINAL));

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule : interp_beat_counter

// File: rtl/interp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// interp_seq_ctrl -- block sequencer for the interpolation filter.
//
// Sequence per block: IDLE --start--> FILL (accept IN_ROWS input rows)
// --> FILTER (emit OUT_WORDS output words) --> DONE (one cycle) --> IDLE.
// With in_valid and out_ready held high a block takes 1+IN_ROWS+OUT_WORDS
// cycles from the start sample to the done pulse.
//
// Build option:
//   INTERP_SEQ_CTRL_ABORT_EN  adds input 'abort'; abort=1 in FILL/FILTER
//                             drops the block and returns to IDLE (no done).
//
// Parameters:
//   IN_ROWS    rows per block (default 15)
//   OUT_WORDS  output words per block (default 40)
//
// Ports:
//   clock       in   rising-edge clock
//   reset_L     in   asynchronous active-low reset
//   abort       in   (option only) abandon the current block
//   start       in   start-of-block request, sampled only in IDLE
//   in_valid    in   upstream row available this cycle
//   in_ready    out  high in FILL
//   in_load_L   out  active-low row load strobe (= ~in_valid in FILL)
//   out_ready   in   downstream can take a word this cycle
//   out_load_L  out  active-low word load strobe (= ~out_ready in FILTER)
//   out_sel     out  index of the word being loaded; holds outside FILTER
//   busy        out  high in any state other than IDLE
//   done        out  one-cycle pulse in the DONE state
// -----------------------------------------------------------------------------
module interp_seq_ctrl
    import interp_pkg::*;
#(
    parameter int IN_ROWS   = IN_ROWS_DEF,
    parameter int OUT_WORDS = OUT_WORDS_DEF
) (
    input  logic             clock,
    input  logic             reset_L,
`ifdef INTERP_SEQ_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             in_load_L,
    input  logic             out_ready,
    output logic             out_load_L,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy,
    output logic             done
);

    state_t             state;
    logic               abort_hit;
    logic               counters_clear;
    logic               row_accept;
    logic               word_accept;
    logic [SEL_W-1:0]   row_count;
    logic               row_last;
    logic [SEL_W-1:0]   word_count;
    logic               word_last;
    logic [SEL_W-1:0]   sel_hold;

    // ---------------------------------------------------------------------
    // Optional abort: only meaningful while a block is in flight.
    // ---------------------------------------------------------------------
`ifdef INTERP_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort && in_block(state);
`else
    assign abort_hit = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Handshake strobes. These follow the upstream/downstream valid/ready
    // inputs combinationally so a row or word moves in the same cycle it is
    // offered; the state gating keeps them inactive outside their phase.
    // ---------------------------------------------------------------------
    assign in_ready    = (state == ST_FILL);
    assign row_accept  = in_ready && in_valid;
    assign in_load_L   = ~row_accept;

    assign word_accept = (state == ST_FILTER) && out_ready;
    assign out_load_L  = ~word_accept;

    // During FILTER the live word counter is shown; elsewhere the last index
    // reached is held, so the counter itself is free to clear for the next
    // block without disturbing out_sel.
    assign out_sel     = (state == ST_FILTER) ? word_count : sel_hold;

    // ---------------------------------------------------------------------
    // Beat counters. Held clear throughout IDLE, so both start at zero on
    // entry to FILL; an abort clears them on the same edge it leaves.
    // ---------------------------------------------------------------------
    assign counters_clear = (state == ST_IDLE) || abort_hit;

    interp_beat_counter #(
        .WIDTH    (SEL_W),
        .TERMINAL (IN_ROWS - 1)
    ) u_row_counter (
        .clock    (clock),
        .reset_L  (reset_L),
        .clear    (counters_clear),
        .enable   (row_accept),
        .count    (row_count),
        .terminal (row_last)
    );

    interp_beat_counter #(
        .WIDTH    (SEL_W),
        .TERMINAL (OUT_WORDS - 1)
    ) u_word_counter (
        .clock    (clock),
        .reset_L  (reset_L),
        .clear    (counters_clear),
        .enable   (word_accept),
        .count    (word_count),
        .terminal (word_last)
    );

    // The row index is only needed through its terminal flag; it is kept as
    // a named net for probing during bring-up.
    logic unused_row_count;
    assign unused_row_count = ^row_count;

    // ---------------------------------------------------------------------
    // Sequencer. busy and done are registered alongside the state so they
    // are glitch-free flop outputs.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sel_hold <= '0;
        end else begin
            done <= 1'b0;

            if (state == ST_FILTER) begin
                sel_hold <= word_count;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FILL;
                        busy  <= 1'b1;
                    end
                end

                ST_FILL: begin
                    if (abort_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (row_accept && row_last) begin
                        state <= ST_FILTER;
                    end
                end

                ST_FILTER: begin
                    if (abort_hit) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (word_accept && word_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : interp_seq_ctrl

// File: tb/tb_interp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interp_seq_ctrl -- directed self-checking bench for interp_seq_ctrl.
// Inputs change 1 ns after the rising edge; strobes are tallied on the falling
// edge. Expected cycle counts are hand-computed for IN_ROWS=15, OUT_WORDS=40.
// Define INTERP_SEQ_CTRL_ABORT_EN to include the abort scenario.
// -----------------------------------------------------------------------------
module tb_interp_seq_ctrl;

    logic       clock;
    logic       reset_L;
    logic       abort;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic       in_load_L;
    logic       out_ready;
    logic       out_load_L;
    logic [7:0] out_sel;
    logic       busy;
    logic       done;

    int n_compared;
    int n_mismatched;

    // Strobe tallies gathered by the falling-edge monitor.
    int n_in_loads;
    int n_out_loads;
    int n_fill_cycles;
    int n_done;
    int n_sel_err;
    int exp_sel;

    interp_seq_ctrl dut (
        .clock      (clock),
        .reset_L    (reset_L),
`ifdef INTERP_SEQ_CTRL_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load_L  (in_load_L),
        .out_ready  (out_ready),
        .out_load_L (out_load_L),
        .out_sel    (out_sel),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!in_load_L) n_in_loads++;
        if (in_ready) n_fill_cycles++;
        if (done) n_done++;
        if (!out_load_L) begin
            if (int'(out_sel) != exp_sel) n_sel_err++;
            exp_sel++;
            n_out_loads++;
        end
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_stats();
        n_in_loads    = 0;
        n_out_loads   = 0;
        n_fill_cycles = 0;
        n_done        = 0;
        n_sel_err     = 0;
        exp_sel       = 0;
    endtask

    // Launches a block from IDLE and runs until done (or until stop_at).
    // vmode=1 toggles in_valid 1/0 starting with 1 in the first FILL cycle.
    // stall=1 drops out_ready for cycles 36..40 (out_sel=20 at defaults).
    // pulse=1 raises start for one cycle during FILL.
    task automatic run_block(input bit vmode, input bit stall, input bit pulse,
                             input int stop_at, output int cycles);
        bit finished;
        clear_stats();
        finished  = 1'b0;
        cycles    = 0;
        start     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock);
            #1;
            cycles++;
            start     = pulse && (cycles == 5);
            in_valid  = vmode ? (cycles % 2 == 1) : 1'b1;
            out_ready = !(stall && cycles >= 36 && cycles <= 40);
            #1;
            if (stall && cycles == 38) begin
                check("stall_out_sel", int'(out_sel), 20);
                check("stall_out_load_L", int'(out_load_L), 1);
            end
            if (done || cycles == stop_at) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check("block_timeout", 0, 1);
        start    = 1'b0;
        in_valid = 1'b1;
    endtask

    initial begin
        int cycles;
        n_compared   = 0;
        n_mismatched = 0;
        clear_stats();
        reset_L   = 1'b0;
        abort     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;

        // --- reset state, with both handshake inputs offered -------------
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_in_load_L", int'(in_load_L), 1);
        check("rst_out_load_L", int'(out_load_L), 1);
        check("rst_out_sel", int'(out_sel), 0);
        reset_L = 1'b1;
        step();
        step();
        check("idle_busy", int'(busy), 0);
        check("idle_in_load_L", int'(in_load_L), 1);

        // --- full-rate block --------------------------------------------
        run_block(1'b0, 1'b0, 1'b0, -1, cycles);
        check("full_latency", cycles, 56);
        check("full_done", int'(done), 1);
        check("full_busy_in_done", int'(busy), 1);
        step();
        check("full_in_loads", n_in_loads, 15);
        check("full_out_loads", n_out_loads, 40);
        check("full_sel_seq_err", n_sel_err, 0);
        check("full_fill_cycles", n_fill_cycles, 15);
        check("full_done_count", n_done, 1);
        check("full_done_dropped", int'(done), 0);
        check("full_busy_after", int'(busy), 0);
        check("full_out_sel_hold", int'(out_sel), 39);
        step();

        // --- in_valid toggling during FILL -------------------------------
        run_block(1'b1, 1'b0, 1'b0, -1, cycles);
        check("gap_latency", cycles, 70);
        step();
        check("gap_in_loads", n_in_loads, 15);
        check("gap_fill_cycles", n_fill_cycles, 29);
        check("gap_out_loads", n_out_loads, 40);
        check("gap_done_count", n_done, 1);
        step();

        // --- out_ready stall at out_sel=20 -------------------------------
        run_block(1'b0, 1'b1, 1'b0, -1, cycles);
        check("stall_latency", cycles, 61);
        step();
        check("stall_out_loads", n_out_loads, 40);
        check("stall_sel_seq_err", n_sel_err, 0);
        step();

        // --- reset mid-FILTER at out_sel=10 (cycle 26) -------------------
        run_block(1'b0, 1'b0, 1'b0, 26, cycles);
        check("mid_out_sel_before", int'(out_sel), 10);
        reset_L = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_out_sel", int'(out_sel), 0);
        check("mid_rst_out_load_L", int'(out_load_L), 1);
        check("mid_rst_in_ready", int'(in_ready), 0);
        check("mid_rst_done", int'(done), 0);
        step();
        reset_L = 1'b1;
        repeat (60) step();
        check("mid_rst_no_done", n_done, 0);
        check("mid_rst_idle", int'(busy), 0);
        run_block(1'b0, 1'b0, 1'b0, -1, cycles);
        check("post_rst_latency", cycles, 56);
        step();
        step();

        // --- start pulses in FILL and in DONE are ignored -----------------
        run_block(1'b0, 1'b0, 1'b1, -1, cycles);
        check("pulse_latency", cycles, 56);
        start = 1'b1;
        #1;
        check("pulse_in_done_busy", int'(busy), 1);
        step();
        start = 1'b0;
        step();
        check("pulse_idle_busy", int'(busy), 0);
        check("pulse_idle_in_ready", int'(in_ready), 0);
        repeat (5) step();
        check("pulse_still_idle", int'(busy), 0);
        check("pulse_done_count", n_done, 1);

`ifdef INTERP_SEQ_CTRL_ABORT_EN
        // --- abort after row 7 accepted (FILL cycle 8) -------------------
        run_block(1'b0, 1'b0, 1'b0, 8, cycles);
        check("abort_in_ready_before", int'(in_ready), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        repeat (60) step();
        check("abort_no_done", n_done, 0);
        run_block(1'b0, 1'b0, 1'b0, -1, cycles);
        check("abort_next_latency", cycles, 56);
        step();
        check("abort_next_in_loads", n_in_loads, 15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_interp_seq_ctrl
